// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter slice.
//
// Contents:
//   ARB_N, ARB_IDX_W         requester count and binary index width
//   ST_IDLE, ST_BUSY         FSM state encoding (1-bit, legacy-compatible)
//   HOLD_MAX_DEF, HOLD_W_DEF default hold-limit parameters
//   idx_to_onehot()          binary index -> one-hot request position
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int HOLD_MAX_DEF = 16;
  localparam int HOLD_W_DEF   = 8;

  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the arbiter.
//
// Signals:
//   en        arbitration enable (requester side -> arbiter)
//   req[7:0]  request vector, bit i = requester i
//   gnt[7:0]  registered one-hot (or zero) grant
//   gnt_valid registered, equals |gnt
//   gnt_idx   registered binary index of the granted requester, 0 when idle
//
// Modports:
//   master  drives en/req, observes the grant
//   slave   the arbiter: observes en/req, drives the grant
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic                 en;
  logic [ARB_N-1:0]     req;
  logic [ARB_N-1:0]     gnt;
  logic                 gnt_valid;
  logic [ARB_IDX_W-1:0] gnt_idx;

  modport master (output en, req, input gnt, gnt_valid, gnt_idx);
  modport slave  (input en, req, output gnt, gnt_valid, gnt_idx);

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin search for eight requesters.
//
// The winner is the first set bit of (req & mask) scanning circularly from
// ptr+1. The masked vector is concatenated with itself and shifted down by
// ptr+1, so the circular scan becomes a plain lowest-set-bit search.
//
// Ports:
//   req[7:0]        request vector
//   ptr[2:0]        last-granted index; the scan starts just after it
//   mask[7:0]       1 = requester may win this search
//   found           a winner exists
//   win_idx[2:0]    binary index of the winner (0 when none)
//   win_onehot[7:0] one-hot winner (0 when none)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  input  logic [ARB_N-1:0]     mask,
  output logic                 found,
  output logic [ARB_IDX_W-1:0] win_idx,
  output logic [ARB_N-1:0]     win_onehot
);

  logic [ARB_N-1:0]     masked;
  logic [2*ARB_N-1:0]   dbl;
  logic [ARB_IDX_W:0]   shift;
  logic [ARB_N-1:0]     rot;
  logic [ARB_IDX_W-1:0] offs;

  assign masked = req & mask;
  assign dbl    = {masked, masked};
  // One extra bit so that ptr=7 shifts by 8 (start at bit 0) instead of 0.
  assign shift  = {1'b0, ptr} + (ARB_IDX_W+1)'(1);
  assign rot    = ARB_N'(dbl >> shift);

  // NOTE: every output of a combinational block gets a default up front, so
  // no path through the loop leaves it unassigned and infers a latch.
  always_comb begin
    found = 1'b0;
    offs  = '0;
    // Scan high-to-low so the lowest set bit (closest to ptr+1) wins last.
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        offs  = ARB_IDX_W'(i);
      end
    end
  end

  assign win_idx    = found ? (ptr + offs + ARB_IDX_W'(1)) : '0;
  assign win_onehot = found ? idx_to_onehot(win_idx) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant, valid and
// binary index outputs (1-cycle request-to-grant latency).
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_arbiter8_if.slave: en, req in; gnt, gnt_valid, gnt_idx out
//
// Parameters:
//   HOLD_MAX  max consecutive grant cycles while others wait (2..255)
//   HOLD_W    hold counter width, 2**HOLD_W > HOLD_MAX
//
// Build option:
//   ARB_HOLD_LIMIT_EN  when defined, a requester that has held the grant for
//                      HOLD_MAX cycles is forced off if anyone else is
//                      waiting. When undefined, a grant is held until its
//                      request drops and no hold counter exists.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
)(
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (64'd1 << HOLD_W) <= 64'(HOLD_MAX)) begin : g_param_check
    $error("rr_arbiter8: HOLD_MAX must be 2..255 and fit in HOLD_W bits");
  end

  logic [0:0]           state;
  logic [ARB_IDX_W-1:0] ptr;        // last granted; current owner while BUSY
  logic [ARB_N-1:0]     gnt_q;
  logic                 gnt_valid_q;
  logic [ARB_IDX_W-1:0] gnt_idx_q;

  logic                 cur_req;
  logic                 force_rot;
  logic [ARB_N-1:0]     pick_mask;
  logic                 found;
  logic [ARB_IDX_W-1:0] win_idx;
  logic [ARB_N-1:0]     win_onehot;
  logic                 hold;
  logic                 issue;

  assign cur_req = bus.req[ptr];

`ifdef ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              others_pending;

  assign others_pending = |(bus.req & ~idx_to_onehot(ptr));
  // ">=" rather than "==": once the counter has saturated with nobody else
  // waiting, a requester that shows up later still gets the grant rotated.
  assign force_rot = (state == ST_BUSY) && cur_req && bus.en && others_pending &&
                     (hold_cnt >= HOLD_W'(HOLD_MAX - 1));
  // A forced rotation must not pick the current owner again.
  assign pick_mask = force_rot ? ~idx_to_onehot(ptr) : '1;

  always_ff @(posedge clk) begin
    if (rst)
      hold_cnt <= '0;
    else if (issue)
      hold_cnt <= '0;
    else if (hold && hold_cnt != HOLD_W'(HOLD_MAX))
      hold_cnt <= hold_cnt + HOLD_W'(1);
  end
`else
  assign force_rot = 1'b0;
  assign pick_mask = '1;
`endif

  rr_pick8 u_pick (
    .req        (bus.req),
    .ptr        (ptr),
    .mask       (pick_mask),
    .found      (found),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  // Owner keeps the grant while it still requests; en is not consulted here,
  // so dropping en never revokes an outstanding grant.
  assign hold  = (state == ST_BUSY) && cur_req && !force_rot;
  // New grant from IDLE, on release (no bubble) or on forced rotation.
  assign issue = !hold && bus.en && found;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= ARB_IDX_W'(ARB_N - 1);   // first search starts at bit 0
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
    end else if (hold) begin
      state       <= ST_BUSY;
    end else if (issue) begin
      state       <= ST_BUSY;
      ptr         <= win_idx;
      gnt_q       <= win_onehot;
      gnt_valid_q <= 1'b1;
      gnt_idx_q   <= win_idx;
    end else begin
      state       <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = gnt_idx_q;

endmodule
